// File: rtl/restoring_divider_pkg.sv
// Shared arithmetic definitions: FSM state encoding and default operand widths
// used by the divider and the accumulator datapath that feeds it.
package restoring_divider_pkg;

    localparam int DW_DEFAULT = 25;
    localparam int VW_DEFAULT = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/restoring_divider_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it does not go negative.
module div_step #(
    parameter int VW = restoring_divider_pkg::VW_DEFAULT
) (
    input  logic [VW:0]   part_rem,
    input  logic          next_bit,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   new_rem,
    output logic          q_bit
);

    localparam int RW = VW + 1;

    logic [VW+1:0] shifted;

    // The shifted value is one bit wider than the partial remainder so the
    // trial compare is exact even before the remainder is reduced.
    always_comb begin
        shifted = {part_rem, next_bit};
        q_bit   = (shifted >= {2'b00, divisor});
        new_rem = q_bit ? RW'(shifted - {2'b00, divisor}) : shifted[VW:0];
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first,
// with results held on registered outputs until the next operation completes.
module restoring_divider #(
    parameter int DW = restoring_divider_pkg::DW_DEFAULT,
    parameter int VW = restoring_divider_pkg::VW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          busy,
    output logic          done,
    output logic          div_by_zero
);

    import restoring_divider_pkg::*;

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    div_state_t    state, next_state;
    logic [DW-1:0] work;
    logic [VW-1:0] div_reg;
    logic [VW:0]   part_rem;
    logic [CW-1:0] cnt;
    logic [VW:0]   step_rem;
    logic          step_q;

    // Dividend bits shift out of the top of work while quotient bits shift in
    // at the bottom, so after DW steps work holds the full quotient.
    div_step #(.VW(VW)) u_step (
        .part_rem (part_rem),
        .next_bit (work[DW-1]),
        .divisor  (div_reg),
        .new_rem  (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = (divisor == '0) ? DONE : RUN;
            RUN:     if (cnt == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work        <= '0;
            div_reg     <= '0;
            part_rem    <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work     <= dividend;
                        div_reg  <= divisor;
                        part_rem <= '0;
                        cnt      <= CW'(DW - 1);
                        // A zero divisor skips RUN and publishes its result immediately.
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[VW-1:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    work     <= {work[DW-2:0], step_q};
                    part_rem <= step_rem;
                    cnt      <= cnt - CW'(1);
                    if (cnt == '0) begin
                        quotient  <= {work[DW-2:0], step_q};
                        remainder <= step_rem[VW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: a transaction-level arithmetic model checked
// every cycle, plus directed scenarios with hand-computed results and latencies.
module tb_restoring_divider;

    localparam int DW = 25;
    localparam int VW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int t0       = 0;
    bit check_en = 1'b0;

    // Model state: expected outputs after each edge
    int            m_left = -1;
    logic [DW-1:0] pend_q, exp_q;
    logic [VW-1:0] pend_r, exp_r;
    logic          exp_busy, exp_done, exp_z;

    restoring_divider #(.DW(DW), .VW(VW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operation-level model: an accepted request finishes DW edges later with
    // plain integer division; a zero divisor finishes on the accepting edge.
    always @(posedge clk) begin
        if (rst) begin
            m_left   = -1;
            exp_q    = '0;
            exp_r    = '0;
            exp_z    = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else if (exp_done) begin
            exp_done = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_left   = -1;
                exp_busy = 1'b0;
                exp_done = 1'b1;
                exp_q    = pend_q;
                exp_r    = pend_r;
            end
        end else if (start) begin
            if (divisor == '0) begin
                exp_done = 1'b1;
                exp_q    = '1;
                exp_r    = dividend[VW-1:0];
                exp_z    = 1'b1;
            end else begin
                exp_busy = 1'b1;
                exp_z    = 1'b0;
                m_left   = DW;
                pend_q   = dividend / {{(DW-VW){1'b0}}, divisor};
                pend_r   = VW'(dividend % {{(DW-VW){1'b0}}, divisor});
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cmp_busy", 64'(busy), 64'(exp_busy));
            checkOutput("cmp_done", 64'(done), 64'(exp_done));
            checkOutput("cmp_quotient", 64'(quotient), 64'(exp_q));
            checkOutput("cmp_remainder", 64'(remainder), 64'(exp_r));
            checkOutput("cmp_div_by_zero", 64'(div_by_zero), 64'(exp_z));
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs, input int hold);
        t0       = cyc;
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        repeat (hold) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, output int done_cyc, output bit busy_seen);
        busy_seen = 1'b0;
        done_cyc  = -1;
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                done_cyc = cyc;
                return;
            end
            busy_seen |= busy;
            @(negedge clk);
        end
        n_checks++;
        $display("[TB] FAIL %s_timeout: got no done, expected done within 60 cycles", name);
    endtask

    task automatic runOp(input string name, input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er, input bit ez, input int elat);
        int dc;
        bit bs;
        applyStimulus(dvd, dvs, 1);
        waitDone(name, dc, bs);
        checkOutput({name, "_latency"}, 64'(dc - t0), 64'(elat));
        checkOutput({name, "_quotient"}, 64'(quotient), 64'(eq));
        checkOutput({name, "_remainder"}, 64'(remainder), 64'(er));
        checkOutput({name, "_div_by_zero"}, 64'(div_by_zero), 64'(ez));
        if (ez) checkOutput({name, "_busy_seen"}, 64'(bs), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int dc, t_first, n_done;
        bit bs;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset_quotient", 64'(quotient), 64'd0);
        checkOutput("reset_remainder", 64'(remainder), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_div_by_zero", 64'(div_by_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        runOp("div_100_7", 25'd100, 12'd7, 25'd14, 12'd2, 1'b0, 26);
        runOp("div_max", 25'h1FFFFFF, 12'hFFF, 25'h0002002, 12'd1, 1'b0, 26);
        runOp("div_5_9", 25'd5, 12'd9, 25'd0, 12'd5, 1'b0, 26);
        runOp("div_zero", 25'd1234, 12'd0, 25'h1FFFFFF, 12'h4D2, 1'b1, 1);
        runOp("dbz_clear", 25'd100, 12'd7, 25'd14, 12'd2, 1'b0, 26);

        // A second request mid-run is ignored; one raised during done waits a cycle
        applyStimulus(25'd100, 12'd7, 1);
        t_first = t0;
        repeat (9) @(negedge clk);
        applyStimulus(25'd50, 12'd5, 1);
        waitDone("overlap", dc, bs);
        checkOutput("overlap_latency", 64'(dc - t_first), 64'd26);
        checkOutput("overlap_quotient", 64'(quotient), 64'd14);
        checkOutput("overlap_remainder", 64'(remainder), 64'd2);
        applyStimulus(25'd50, 12'd5, 2);
        waitDone("after_done", dc, bs);
        checkOutput("after_done_latency", 64'(dc - t0), 64'd27);
        checkOutput("after_done_quotient", 64'(quotient), 64'd10);
        checkOutput("after_done_remainder", 64'(remainder), 64'd0);
        @(negedge clk);

        // Reset partway through an operation aborts it silently
        applyStimulus(25'd100, 12'd7, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_quotient", 64'(quotient), 64'd0);
        checkOutput("abort_remainder", 64'(remainder), 64'd0);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_div_by_zero", 64'(div_by_zero), 64'd0);
        rst    = 1'b0;
        n_done = 0;
        repeat (40) begin
            if (done) n_done++;
            @(negedge clk);
        end
        checkOutput("abort_no_done", 64'(n_done), 64'd0);
        runOp("after_reset", 25'd100, 12'd7, 25'd14, 12'd2, 1'b0, 26);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
